// File: rtl/regfile_read_unit.sv
// -----------------------------------------------------------------------------
// regfile_read_unit
//   Read side of the core register file. Holds NREG x WIDTH architectural
//   registers (register 0 reads as zero and is never written or marked busy),
//   accepts decode read requests over a valid/ready handshake and returns both
//   operands one cycle after acceptance. A pending-write scoreboard (busy)
//   stalls requests whose sources have outstanding writebacks, and requests
//   whose destination is already pending (WAW).
//
//   Optional feature: define REGFILE_BYPASS_EN to let a same-cycle writeback
//   to a source register clear its hazard and forward wb_data as the operand.
//   Without it, a source stays blocked until the cycle after its busy bit
//   clears and operands always come from the array.
//
// Ports
//   clk        in   1      rising-edge clock
//   rstn       in   1      asynchronous active-low reset
//   req_valid  in   1      read request present
//   req_ready  out  1      request accepted when req_valid & req_ready
//   rs1, rs2   in   AW     source register indices
//   rd         in   AW     destination index to mark pending
//   rd_alloc   in   1      mark rd pending on accept
//   wb_en      in   1      writeback strobe
//   wb_addr    in   AW     writeback register index
//   wb_data    in   WIDTH  writeback data
//   rsp_valid  out  1      operands valid
//   rsp_ready  in   1      consumer takes operands
//   rs1_data   out  WIDTH  operand 1
//   rs2_data   out  WIDTH  operand 2
//   busy       out  NREG   bit i set while a write to register i is outstanding
// -----------------------------------------------------------------------------
module regfile_read_unit #(
    parameter int WIDTH = 32,
    parameter int NREG  = 32,
    parameter int AW    = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [AW-1:0]    rs1,
    input  logic [AW-1:0]    rs2,
    input  logic [AW-1:0]    rd,
    input  logic             rd_alloc,
    input  logic             wb_en,
    input  logic [AW-1:0]    wb_addr,
    input  logic [WIDTH-1:0] wb_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rs1_data,
    output logic [WIDTH-1:0] rs2_data,
    output logic [NREG-1:0]  busy
);

    logic [WIDTH-1:0] regs [NREG];

    logic             haz1;
    logic             haz2;
    logic             waw;
    logic             accept;
    logic             wb_write;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;

    assign wb_write = wb_en && (wb_addr != '0);

    always_comb begin
        haz1 = 1'b0;
        haz2 = 1'b0;
        op1  = '0;
        op2  = '0;
`ifdef REGFILE_BYPASS_EN
        // A writeback landing this cycle both resolves the hazard and
        // supplies the operand directly.
        if (rs1 != '0) begin
            if (wb_en && (wb_addr == rs1)) begin
                op1 = wb_data;
            end else begin
                haz1 = busy[rs1];
                op1  = regs[rs1];
            end
        end
        if (rs2 != '0) begin
            if (wb_en && (wb_addr == rs2)) begin
                op2 = wb_data;
            end else begin
                haz2 = busy[rs2];
                op2  = regs[rs2];
            end
        end
`else
        // No forwarding: a same-cycle write is not visible until next cycle.
        if (rs1 != '0) begin
            haz1 = busy[rs1];
            op1  = regs[rs1];
        end
        if (rs2 != '0) begin
            haz2 = busy[rs2];
            op2  = regs[rs2];
        end
`endif
    end

    // WAW stall ignores any same-cycle writeback to rd.
    assign waw       = rd_alloc && (rd != '0) && busy[rd];
    assign req_ready = !(rsp_valid && !rsp_ready) && !haz1 && !haz2 && !waw;
    assign accept    = req_valid && req_ready;

    // Register array: register 0 is never written, so it stays zero.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_write) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // Scoreboard: the allocation is written last so a same-cycle set wins
    // over the writeback clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy <= '0;
        end else begin
            if (wb_write) begin
                busy[wb_addr] <= 1'b0;
            end
            if (accept && rd_alloc && (rd != '0)) begin
                busy[rd] <= 1'b1;
            end
        end
    end

    // Response stage: captured on accept, held while the consumer stalls.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rsp_valid <= 1'b0;
            rs1_data  <= '0;
            rs2_data  <= '0;
        end else if (accept) begin
            rsp_valid <= 1'b1;
            rs1_data  <= op1;
            rs2_data  <= op2;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule
